// File: rtl/snoop_bus_pkg.sv
// Shared definitions for the snooping bus controller: bus-word layout,
// cache-state and controller FSM encodings, default sizes.
package snoop_bus_pkg;

    localparam int NPROC_DEFAULT     = 4;
    localparam int MEM_DEPTH_DEFAULT = 128;

    // Bus word: {wb, hit, state[1:0], data[7:0]}
    localparam int WORD_W   = 12;
    localparam int WB_BIT   = 11;
    localparam int HIT_BIT  = 10;
    localparam int STATE_HI = 9;
    localparam int STATE_LO = 8;
    localparam int DATA_HI  = 7;
    localparam int DATA_LO  = 0;

    typedef enum logic [1:0] {
        INVALID  = 2'd0,
        SHARED   = 2'd1,
        MODIFIED = 2'd2
    } cache_state_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARB    = 3'd1,
        ST_ISSUE0 = 3'd2,
        ST_ISSUE1 = 3'd3,
        ST_WB     = 3'd4,
        ST_DONE   = 3'd5
    } bus_state_t;

endpackage

// File: rtl/main_memory.sv
// Backing store behind the snooping bus: synchronous write, registered read.
// Contents are deliberately left unreset.
module main_memory #(
    parameter int DEPTH = 128,
    parameter int WIDTH = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clock,
    input  logic             we,
    input  logic             re,
    input  logic [AW-1:0]    addr,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/snoop_bus_controller.sv
// Shared-bus controller for snooping caches: round-robin arbitration, request
// broadcast, bus-word resolution and main-memory ownership.
module snoop_bus_controller
    import snoop_bus_pkg::*;
#(
    parameter int NPROC     = NPROC_DEFAULT,
    parameter int MEM_DEPTH = MEM_DEPTH_DEFAULT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [NPROC-1:0]        req,
    input  logic [NPROC-1:0]        req_op,
    input  logic [2*NPROC-1:0]      req_block,
    input  logic [5*NPROC-1:0]      req_tag,
    input  logic [8*NPROC-1:0]      req_data,
    input  logic [WORD_W*NPROC-1:0] proc_bus_out,
    output logic [NPROC-1:0]        start,
    output logic [NPROC-1:0]        listen,
    output logic [1:0]              p2,
    output logic                    op,
    output logic [1:0]              block,
    output logic [4:0]              tag_in,
    output logic [7:0]              wr_data,
    output logic [WORD_W-1:0]       bus_in,
    output logic                    busy,
    output logic [NPROC-1:0]        done
);

    localparam int AW = $clog2(MEM_DEPTH);

    bus_state_t state_reg;
    logic [1:0] ptr_reg;

    logic [1:0]        blk_arr  [NPROC];
    logic [4:0]        tag_arr  [NPROC];
    logic [7:0]        dat_arr  [NPROC];
    logic [WORD_W-1:0] word_arr [NPROC];

    logic [NPROC-1:0] p2_onehot;
    logic [NPROC-1:0] hit_vec;
    logic [NPROC-1:0] wb_vec;

    // Per-processor unpacking; the requester's own word never counts as a snoop response.
    generate
        for (genvar gi = 0; gi < NPROC; gi++) begin : g_proc
            localparam logic [1:0] IDX = 2'(gi);
            assign blk_arr[gi]   = req_block[2*gi +: 2];
            assign tag_arr[gi]   = req_tag[5*gi +: 5];
            assign dat_arr[gi]   = req_data[8*gi +: 8];
            assign word_arr[gi]  = proc_bus_out[WORD_W*gi +: WORD_W];
            assign p2_onehot[gi] = (p2 == IDX);
            assign hit_vec[gi]   = word_arr[gi][HIT_BIT] && (p2 != IDX);
            assign wb_vec[gi]    = word_arr[gi][WB_BIT]  && (p2 != IDX);
        end
    endgenerate

    // Round-robin search starting just above the last winner, wrapping back to it.
    logic       grant_valid;
    logic [1:0] grant_idx;
    logic [1:0] cand;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = NPROC; k >= 1; k--) begin
            cand = ptr_reg + 2'(k);
            if (req[cand]) begin
                grant_valid = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // Lowest-index listener wins for both hit data and write-back data.
    logic                    hit_found;
    logic [STATE_HI:DATA_LO] hit_word;
    logic                    wb_found;
    logic [DATA_HI:DATA_LO]  wb_data;

    always_comb begin
        hit_found = 1'b0;
        hit_word  = '0;
        wb_found  = 1'b0;
        wb_data   = '0;
        for (int k = NPROC - 1; k >= 0; k--) begin
            if (hit_vec[k]) begin
                hit_found = 1'b1;
                hit_word  = word_arr[k][STATE_HI:DATA_LO];
            end
            if (wb_vec[k]) begin
                wb_found = 1'b1;
                wb_data  = word_arr[k][DATA_HI:DATA_LO];
            end
        end
    end

    logic [7:0]    mem_q;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic          mem_re;

    assign mem_addr = AW'({tag_in, block});
    assign mem_re   = (state_reg == ST_ARB);
    assign mem_we   = (state_reg == ST_WB) && wb_found;

    main_memory #(
        .DEPTH (MEM_DEPTH),
        .WIDTH (8)
    ) u_mem (
        .clock (clock),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (wb_data),
        .rdata (mem_q)
    );

    always_comb begin
        bus_in = '0;
        if (state_reg == ST_ISSUE0 || state_reg == ST_ISSUE1) begin
            if (hit_found) begin
                bus_in = {1'b0, 1'b1, hit_word};
            end else if (!op) begin
                bus_in = {1'b0, 1'b1, INVALID, mem_q};
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_IDLE;
            ptr_reg   <= '0;
            start     <= '0;
            listen    <= '0;
            done      <= '0;
            busy      <= 1'b0;
            p2        <= '0;
            op        <= 1'b0;
            block     <= '0;
            tag_in    <= '0;
            wr_data   <= '0;
        end else begin
            done <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (grant_valid) begin
                        p2        <= grant_idx;
                        op        <= req_op[grant_idx];
                        block     <= blk_arr[grant_idx];
                        tag_in    <= tag_arr[grant_idx];
                        wr_data   <= dat_arr[grant_idx];
                        busy      <= 1'b1;
                        state_reg <= ST_ARB;
                    end
                end
                ST_ARB: begin
                    start     <= p2_onehot;
                    listen    <= ~p2_onehot;
                    state_reg <= ST_ISSUE0;
                end
                ST_ISSUE0: begin
                    state_reg <= ST_ISSUE1;
                end
                ST_ISSUE1: begin
                    start     <= '0;
                    listen    <= '0;
                    state_reg <= ST_WB;
                end
                ST_WB: begin
                    done      <= p2_onehot;
                    state_reg <= ST_DONE;
                end
                ST_DONE: begin
                    busy      <= 1'b0;
                    ptr_reg   <= p2;
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
